// File: rtl/stump_bus_responder.sv
// Stump bus slave: word-addressed RAM plus an I/O page (TX byte FIFO, status, timer, switches).
// Define STUMP_TIMER_EN to build the free-running TIMER register at 0xFF02.
module stump_bus_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  switches
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
    localparam logic [15:0] ADDR_STATUS = 16'hFF01;
    localparam logic [15:0] ADDR_TIMER  = 16'hFF02;
    localparam logic [15:0] ADDR_SWITCH = 16'hFF03;

    // ---------------- RAM ----------------
    logic [15:0]   ram_q [MEM_WORDS];
    logic          ram_sel;
    logic [AW-1:0] ram_idx;
    logic          ram_we;

    assign ram_sel = (address[15:AW] == '0);
    assign ram_idx = address[AW-1:0];
    assign ram_we  = mem_wen && ram_sel;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= data_out;
        end
    end

    // ---------------- Output FIFO ----------------
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, empty;
    logic          push_req, push, pop, ovf_set, ovf_clr;

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = mem_wen && (address == ADDR_TXDATA);
    assign pop      = tx_ready && !empty;
    // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = mem_wen && (address == ADDR_STATUS) && data_out[8];

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = data_out[7:0];
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    // ---------------- TIMER ----------------
    logic [15:0] timer_rd;

`ifdef STUMP_TIMER_EN
    logic [15:0] timer_q, timer_d;

    always_comb begin
        if (mem_wen && (address == ADDR_TIMER)) begin
            timer_d = data_out;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = '0;
`endif

    // ---------------- Switch synchroniser ----------------
    logic [7:0] sw_meta_q, sw_meta_d;
    logic [7:0] sw_sync_q, sw_sync_d;

    always_comb begin
        sw_meta_d = switches;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // ---------------- Read mux ----------------
    logic [15:0] status_word;
    logic [15:0] rd_val;

    always_comb begin
        status_word      = '0;
        status_word[0]   = full;
        status_word[1]   = empty;
        status_word[7:4] = 4'(count_q);
        status_word[8]   = ovf_q;
    end

    always_comb begin
        rd_val = '0;
        if (ram_sel) begin
            rd_val = ram_q[ram_idx];
        end else begin
            case (address)
                ADDR_STATUS: rd_val = status_word;
                ADDR_TIMER:  rd_val = timer_rd;
                ADDR_SWITCH: rd_val = {8'h00, sw_sync_q};
                default:     rd_val = '0;
            endcase
        end
        data_in = (mem_ren && !mem_wen) ? rd_val : '0;
    end

endmodule

// File: tb/tb_stump_bus_responder.sv
// Bench for stump_bus_responder: vector table, directed corner sequences, then random traffic
// checked against a queue-based behavioural model.
module tb_stump_bus_responder;

    localparam int MEM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = '0;
    logic [15:0] data_out = '0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic [15:0] data_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  switches = '0;

    always #5 clk = ~clk;

    stump_bus_responder #(
        .MEM_WORDS (MEM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .data_out(data_out),
        .mem_wen (mem_wen),
        .mem_ren (mem_ren),
        .data_in (data_in),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .switches(switches)
    );

    typedef struct {
        bit          wen;
        bit          ren;
        logic [15:0] addr;
        logic [15:0] dout;
        bit          ready;
        bit          chk_din;
        logic [15:0] exp_din;
        bit          chk_tx;
        bit          exp_valid;
        logic [7:0]  exp_txd;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [15:0] ram_m [int];
    logic [7:0]  q_m [$];
    bit          ovf_m;
    logic [15:0] timer_m;
    logic [7:0]  sw_hist [2];

    vec_t tbl [$];

    function automatic vec_t mk(bit wen, bit ren, logic [15:0] a, logic [15:0] d, bit rdy,
                                bit cd, logic [15:0] ed, bit ct, bit ev, logic [7:0] et);
        vec_t v;
        v.wen = wen; v.ren = ren; v.addr = a; v.dout = d; v.ready = rdy;
        v.chk_din = cd; v.exp_din = ed; v.chk_tx = ct; v.exp_valid = ev; v.exp_txd = et;
        return v;
    endfunction

    task automatic check(input string tag, input string what, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s %s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s      = '0;
        s[0]   = (q_m.size() == FIFO_DEPTH);
        s[1]   = (q_m.size() == 0);
        s[7:4] = 4'(q_m.size());
        s[8]   = ovf_m;
        return s;
    endfunction

    function automatic bit model_read(input logic [15:0] a, output logic [15:0] v);
        v = '0;
        if (int'(a) < MEM_WORDS) begin
            if (ram_m.exists(int'(a))) begin
                v = ram_m[int'(a)];
                return 1'b1;
            end
            return 1'b0;
        end
        case (a)
            16'hFF01: v = model_status();
`ifdef STUMP_TIMER_EN
            16'hFF02: v = timer_m;
`endif
            16'hFF03: v = {8'h00, sw_hist[1]};
            default:  v = '0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_m.delete();
        ovf_m      = 1'b0;
        timer_m    = '0;
        sw_hist[0] = '0;
        sw_hist[1] = '0;
    endtask

    task automatic model_edge(input vec_t v);
        bit pop;
        bit set;
        pop = v.ready && (q_m.size() != 0);
        set = 1'b0;
        if (pop) void'(q_m.pop_front());
        if (v.wen && v.addr == 16'hFF00) begin
            if (q_m.size() < FIFO_DEPTH) q_m.push_back(v.dout[7:0]);
            else set = 1'b1;
        end
        if (set) ovf_m = 1'b1;
        else if (v.wen && v.addr == 16'hFF01 && v.dout[8]) ovf_m = 1'b0;
        if (v.wen && v.addr == 16'hFF02) timer_m = v.dout;
        else timer_m = timer_m + 16'd1;
        if (v.wen && int'(v.addr) < MEM_WORDS) ram_m[int'(v.addr)] = v.dout;
        sw_hist[1] = sw_hist[0];
        sw_hist[0] = switches;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input vec_t v, input string tag);
        logic [15:0] e;
        bit          known;
        mem_wen  = v.wen;
        mem_ren  = v.ren;
        address  = v.addr;
        data_out = v.dout;
        tx_ready = v.ready;
        #1;
        if (v.chk_din) check(tag, "data_in", data_in, v.exp_din);
        if (v.chk_tx) begin
            check(tag, "tx_valid", 16'(tx_valid), 16'(v.exp_valid));
            check(tag, "tx_data", 16'(tx_data), 16'(v.exp_txd));
        end
        if (v.ren && !v.wen) begin
            known = model_read(v.addr, e);
        end else begin
            known = 1'b1;
            e     = '0;
        end
        if (known) check(tag, "model data_in", data_in, e);
        check(tag, "model tx_valid", 16'(tx_valid), 16'(q_m.size() != 0));
        check(tag, "model tx_data", 16'(tx_data), (q_m.size() != 0) ? 16'(q_m[0]) : 16'h0000);
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t0, t1, t2;
`ifdef STUMP_TIMER_EN
        t0 = 16'hFFFE; t1 = 16'hFFFF; t2 = 16'h0000;
`else
        t0 = 16'h0000; t1 = 16'h0000; t2 = 16'h0000;
`endif
        // Reset values / RAM / decode
        tbl.push_back(mk(0,1,16'hFF02,0,0, 1,16'h0000, 1,0,8'h00));
        tbl.push_back(mk(0,1,16'hFF03,0,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0002, 0,0,0));
        tbl.push_back(mk(1,0,16'h0005,16'h1234,0, 1,16'h0000, 1,0,8'h00));
        tbl.push_back(mk(0,1,16'h0005,0,0, 1,16'h1234, 0,0,0));
        tbl.push_back(mk(0,1,16'h0400,0,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(1,0,16'h0000,16'h5555,0, 0,0, 0,0,0));
        tbl.push_back(mk(1,0,16'h0400,16'hBEEF,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'h0000,0,0, 1,16'h5555, 0,0,0));
        tbl.push_back(mk(0,1,16'h0005,0,0, 1,16'h1234, 0,0,0));
        // Fill, overflow, clear
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,0,16'hFF00,16'(8'h41 + i),0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0081, 1,1,8'h41));
        tbl.push_back(mk(1,0,16'hFF00,16'h0049,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0181, 1,1,8'h41));
        tbl.push_back(mk(1,1,16'hFF01,16'h00FF,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0181, 0,0,0));
        tbl.push_back(mk(1,0,16'hFF01,16'h0100,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0081, 0,0,0));
        // Drain, then refill across the wrap
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,16'h0000,0,1, 0,0, 1,1,8'(8'h41 + i)));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0002, 1,0,8'h00));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,16'hFF00,16'(8'h61 + i),0, 0,0, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,16'h0000,0,1, 0,0, 1,1,8'(8'h61 + i)));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0002, 1,0,8'h00));
        // Push and pop together while full
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,0,16'hFF00,16'(8'h71 + i),0, 0,0, 0,0,0));
        tbl.push_back(mk(1,0,16'hFF00,16'h0079,1, 0,0, 1,1,8'h71));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0081, 1,1,8'h72));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,16'h0000,0,1, 0,0, 1,1,8'(8'h72 + i)));
        tbl.push_back(mk(0,1,16'hFF01,0,0, 1,16'h0002, 1,0,8'h00));
        // Timer load and wrap
        tbl.push_back(mk(1,0,16'hFF02,16'hFFFE,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF02,0,0, 1,t0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF02,0,0, 1,t1, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF02,0,0, 1,t2, 0,0,0));
        // Unmapped and read-only locations
        tbl.push_back(mk(1,0,16'h1234,16'hABCD,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'h1234,0,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF04,0,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF00,0,0, 1,16'h0000, 0,0,0));
        tbl.push_back(mk(1,0,16'hFF03,16'hFFFF,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,16'hFF03,0,0, 1,16'h0000, 1,0,8'h00));

        // Reset
        repeat (2) @(negedge clk);
        #1;
        check("reset", "data_in", data_in, 16'h0000);
        check("reset", "tx_valid", 16'(tx_valid), 16'h0000);
        check("reset", "tx_data", 16'(tx_data), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Switch synchroniser: visible after two rising edges
        switches = 8'hA5;
        step(mk(0,1,16'hFF03,0,0, 1,16'h0000, 0,0,0), "sw0");
        step(mk(0,1,16'hFF03,0,0, 1,16'h0000, 0,0,0), "sw1");
        step(mk(0,1,16'hFF03,0,0, 1,16'h00A5, 0,0,0), "sw2");

        // Reset pulsed between edges with five bytes queued
        for (int i = 0; i < 5; i++)
            step(mk(1,0,16'hFF00,16'(8'h11 + i),0, 0,0, 0,0,0), "pre_rst");
        check("mid_rst", "tx_valid before", 16'(tx_valid), 16'h0001);
        rst = 1'b1;
        #1;
        check("mid_rst", "tx_valid", 16'(tx_valid), 16'h0000);
        check("mid_rst", "tx_data", 16'(tx_data), 16'h0000);
        #1;
        rst = 1'b0;
        model_reset();
        step(mk(0,1,16'hFF01,0,0, 1,16'h0002, 1,0,8'h00), "post_rst_status");
        step(mk(0,1,16'h0005,0,0, 1,16'h1234, 0,0,0), "post_rst_ram");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            vec_t        v;
            logic [15:0] a;
            case ($urandom_range(0, 7))
                0, 1:    a = 16'($urandom_range(0, 7));
                2:       a = 16'(MEM_WORDS - 1 - int'($urandom_range(0, 3)));
                3:       a = 16'(MEM_WORDS + int'($urandom_range(0, 7)));
                4, 5:    a = 16'hFF00 + 16'($urandom_range(0, 3));
                6:       a = 16'hFF00;
                default: a = ($urandom_range(0, 1) != 0) ? 16'hFF04 : 16'(16'h8000 | 16'($urandom_range(0, 15)));
            endcase
            if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
            v = mk(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7), a, 16'($urandom),
                   ($urandom_range(0, 2) == 0), 0, 0, 0, 0, 0);
            step(v, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stump_bus_responder.md
# stump_bus_responder

Memory-side responder for the Stump processor bus: word-addressed RAM plus a small memory-mapped I/O page (output byte FIFO, status, cycle timer, switch input). It connects directly to the processor's `address`, `data_out`, `mem_wen` and `mem_ren` outputs and drives the processor's `data_in`. It sits beside the processor in the system top level and is the only bus slave.

## Interface
- `MEM_WORDS`, default 1024: RAM depth in 16-bit words, power of two, at most 32768; mapped at 0x0000 to MEM_WORDS-1.
- `FIFO_DEPTH`, default 8: output FIFO depth, power of two, 2 to 8.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address`  in  16  word address from the processor.
- `data_out`  in  16  write data from the processor.
- `mem_wen`  in  1  write enable; takes effect on the rising edge.
- `mem_ren`  in  1  read enable.
- `data_in`  out  16  read data to the processor; combinational.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head byte on an edge where `tx_valid` is also high.
- `switches`  in  8  asynchronous external inputs.

## Operation
- **Address map**
  - 0x0000 to MEM_WORDS-1: RAM.
  - 0xFF00 `TXDATA`: a write pushes `data_out[7:0]`; reads return 0.
  - 0xFF01 `STATUS`: bit0 full, bit1 empty, bits[7:4] count, bit8 overflow (sticky); other bits 0. Writing with bit8=1 clears overflow; all other written bits are ignored.
  - 0xFF02 `TIMER`: 16-bit free-running counter; a write loads it.
  - 0xFF03 `SWITCH`: synchronised switches in bits[7:0]; bits[15:8] are 0; writes are ignored.
  - Any other address: reads return 0x0000, writes are ignored.
- **Reads**
  - `data_in` = selected value while `mem_ren`=1 and `mem_wen`=0; otherwise 0x0000.
  - Reads have no side effects.
- **Writes**
  - `mem_wen`=1 writes on the rising edge.
  - If `mem_wen` and `mem_ren` are both high, the cycle is a write and `data_in`=0x0000.
- **RAM:** asynchronous read, synchronous write; contents are not reset.
- **FIFO**
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth. Count runs 0 to FIFO_DEPTH.
  - Push to a non-full FIFO: stored at the tail.
  - Push while full with no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle: both occur and count is unchanged. This includes the full case, which does not set overflow.
  - Pop while empty: impossible, since `tx_valid`=0.
  - Overflow set and clear in the same cycle: set wins.
- **TIMER:** +1 every cycle, wrapping 0xFFFF to 0x0000. A write loads `data_out`, and the load takes priority over the increment that cycle.
- **SWITCH:** two-flop synchroniser, value reset to 0x00.

## Timing
- Reset values: `data_in`=0x0000 (no read in progress), `tx_valid`=0, `tx_data`=0x00, count 0, pointers 0, overflow 0, TIMER 0x0000, synchroniser 0x00.
- Reset asserted mid-operation empties the FIFO immediately. RAM is untouched.
- Read latency is 0 cycles: `data_in` is valid in the same cycle as `address`/`mem_ren`.
- A push at edge N gives `tx_valid`=1 and `tx_data` equal to the byte after edge N. A status read in cycle N+1 shows the new count.
- A pop at edge N presents the next head after edge N.
- A TIMER write at edge N reads back the written value in cycle N+1 and value+1 in N+2.
- A switch change reaches `SWITCH` reads after 2 edges.

## Configuration
- `STUMP_TIMER_EN` defined: TIMER is implemented as above.
- `STUMP_TIMER_EN` undefined: no counter logic; 0xFF02 reads 0x0000 and writes are ignored.

## Test plan
- **RAM:** write 0x1234 to 0x0005, then read 0x0005 → `data_in`=0x1234. Read 0x0400 (MEM_WORDS=1024) → 0x0000. Write to 0x0400 → no RAM word changes.
- **FIFO fill/overflow:** with `tx_ready`=0, push 0x41 to 0x48 (8 bytes) → STATUS=0x0081. Push a ninth byte → STATUS=0x0181 and `tx_data`=0x41. Write 0x0100 to STATUS → 0x0081.
- **Drain/wrap:** with `tx_ready`=1, 8 pops give 0x41 to 0x48 in order, then `tx_valid`=0 and STATUS=0x0002. Push 3 more bytes → they are output in order across the pointer wrap.
- **Simultaneous push/pop at full:** FIFO full with `tx_ready`=1 and a push → count stays 8, overflow stays 0, and the new byte exits eighth.
- **Timer:** write 0xFFFE to 0xFF02 → reads 0xFFFE, 0xFFFF, 0x0000 in successive cycles. Without `STUMP_TIMER_EN` the reads give 0x0000.
- **Reset mid-operation:** FIFO holding 5 bytes, `rst` pulsed between edges → `tx_valid`=0 immediately and STATUS=0x0002. RAM word 0x0005 still reads 0x1234.
